// File: rtl/ffd_bank_write_ctrl_pkg.sv
// Shared definitions for the register-bank write sequencer: FSM state
// encoding, requester identifiers and default bank geometry.
package ffd_bank_write_ctrl_pkg;

    localparam int NREG_DEF   = 6;
    localparam int DATA_W_DEF = 3;

    // Sequencer states; the encoding is exposed on the fsm_state debug port.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        ACK   = 3'd2,
        SWEEP = 3'd3,
        SDONE = 3'd4
    } state_t;

    // Requester identity: A is the keypad path, B the device read-back path.
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/ffd_bank_write_ctrl_if.sv
// Request/acknowledge bus between the control logic (master) and the bank
// write sequencer (slave), including the data/enable bus to the bank.
//
// Handshake: req_a, req_b and clr_req are levels. Once raised, a request and
// its address/data must stay stable until the matching one-cycle ack_a,
// ack_b or clr_done pulse is seen. A request still high in the cycle after
// its acknowledge is taken as a new request.
interface ffd_bank_write_ctrl_if #(
    parameter int NREG   = 6,
    parameter int DATA_W = 3
);
    localparam int ADDR_W = $clog2(NREG);

    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic              req_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] data_b;
    logic              clr_req;

    logic [DATA_W-1:0] datos_out;
    logic [NREG-1:0]   enable_out;
    logic              ack_a;
    logic              ack_b;
    logic              clr_done;
    logic              err;
    logic              busy;

    modport master (
        output req_a, addr_a, data_a, req_b, addr_b, data_b, clr_req,
        input  datos_out, enable_out, ack_a, ack_b, clr_done, err, busy
    );

    modport slave (
        input  req_a, addr_a, data_a, req_b, addr_b, data_b, clr_req,
        output datos_out, enable_out, ack_a, ack_b, clr_done, err, busy
    );

endinterface

// File: rtl/ffd_bank_write_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter. The grant is combinational from the current
// requests; the last-granted pointer only moves when the grant is taken,
// so a contested pair alternates between A and B.
module rr_arbiter2
    import ffd_bank_write_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req_a,
    input  logic    req_b,
    input  logic    take,
    output logic    grant_valid,
    output req_id_t grant_id
);

    req_id_t last_grant;

    // Pick the requester; on contention favour the one not granted last.
    always_comb begin
        grant_valid = req_a | req_b;
        grant_id    = REQ_A;
        if (req_a && req_b) begin
            grant_id = (last_grant == REQ_B) ? REQ_A : REQ_B;
        end else if (req_b) begin
            grant_id = REQ_B;
        end
    end

    // Remember who was served; reset to B so A wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= REQ_B;
        end else if (take && grant_valid) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/ffd_bank_write_ctrl.sv
// Arbitrated write sequencer for a bank of enable-loaded data registers.
// Grants one requester at a time, drives the shared data bus with a one-hot
// enable strobe held for EN_CYCLES cycles, then acknowledges. A clear-all
// sweep writes zero into every register in index order.
module ffd_bank_write_ctrl
    import ffd_bank_write_ctrl_pkg::*;
#(
    parameter int NREG      = NREG_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int EN_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    ffd_bank_write_ctrl_if.slave   bus,
    output state_t                 fsm_state
);

    localparam int ADDR_W = $clog2(NREG);
    localparam int CNT_W  = $clog2(EN_CYCLES + 1);

    localparam logic [CNT_W-1:0]  LAST_HOLD = CNT_W'(EN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREG - 1);

    state_t            state;
    logic [DATA_W-1:0] datos_r;
    logic [NREG-1:0]   enable_r;
    logic              ack_a_r;
    logic              ack_b_r;
    logic              clr_done_r;
    logic              err_r;
    logic              busy_r;
    logic [CNT_W-1:0]  hold_cnt;
    logic [ADDR_W-1:0] sweep_idx;
    logic [ADDR_W-1:0] addr_r;
    req_id_t           grant_r;

    logic              grant_valid;
    req_id_t           grant_id;
    logic              take;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] sweep_next;
    logic              addr_bad;
    logic              hold_done;

    // One-hot decode of a register index; indices past the bank decode to
    // zero, so an out-of-range write never strobes any register.
    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == ADDR_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // The pointer only advances for a real write grant, never for a sweep.
    assign take = (state == IDLE) && !bus.clr_req;

    rr_arbiter2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_a       (bus.req_a),
        .req_b       (bus.req_b),
        .take        (take),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign sel_addr   = (grant_id == REQ_A) ? bus.addr_a : bus.addr_b;
    assign sel_data   = (grant_id == REQ_A) ? bus.data_a : bus.data_b;
    assign sweep_next = sweep_idx + ADDR_W'(1);
    assign addr_bad   = (32'(addr_r) >= NREG);
    assign hold_done  = (hold_cnt == LAST_HOLD);

    // Sequencer FSM with all bank-facing outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            datos_r    <= '0;
            enable_r   <= '0;
            ack_a_r    <= 1'b0;
            ack_b_r    <= 1'b0;
            clr_done_r <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            hold_cnt   <= '0;
            sweep_idx  <= '0;
            addr_r     <= '0;
            grant_r    <= REQ_A;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        // Clear-all outranks any pending write.
                        state     <= SWEEP;
                        busy_r    <= 1'b1;
                        datos_r   <= '0;
                        sweep_idx <= '0;
                        hold_cnt  <= '0;
                        enable_r  <= onehot('0);
                    end else if (grant_valid) begin
                        state    <= WRITE;
                        busy_r   <= 1'b1;
                        grant_r  <= grant_id;
                        addr_r   <= sel_addr;
                        datos_r  <= sel_data;
                        hold_cnt <= '0;
                        enable_r <= onehot(sel_addr);
                    end
                end

                WRITE: begin
                    if (hold_done) begin
                        state    <= ACK;
                        enable_r <= '0;
                        ack_a_r  <= (grant_r == REQ_A);
                        ack_b_r  <= (grant_r == REQ_B);
                        err_r    <= addr_bad;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                ACK: begin
                    // datos_r is left alone: the bus keeps its last value.
                    state   <= IDLE;
                    ack_a_r <= 1'b0;
                    ack_b_r <= 1'b0;
                    err_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end

                SWEEP: begin
                    if (hold_done) begin
                        hold_cnt <= '0;
                        if (sweep_idx == LAST_IDX) begin
                            state      <= SDONE;
                            enable_r   <= '0;
                            clr_done_r <= 1'b1;
                            sweep_idx  <= '0;
                        end else begin
                            // Next strobe follows immediately, no gap cycle.
                            sweep_idx <= sweep_next;
                            enable_r  <= onehot(sweep_next);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                SDONE: begin
                    state      <= IDLE;
                    clr_done_r <= 1'b0;
                    busy_r     <= 1'b0;
                end

                default: begin
                    state      <= IDLE;
                    enable_r   <= '0;
                    ack_a_r    <= 1'b0;
                    ack_b_r    <= 1'b0;
                    clr_done_r <= 1'b0;
                    err_r      <= 1'b0;
                    busy_r     <= 1'b0;
                    hold_cnt   <= '0;
                    sweep_idx  <= '0;
                end
            endcase
        end
    end

    assign bus.datos_out  = datos_r;
    assign bus.enable_out = enable_r;
    assign bus.ack_a      = ack_a_r;
    assign bus.ack_b      = ack_b_r;
    assign bus.clr_done   = clr_done_r;
    assign bus.err        = err_r;
    assign bus.busy       = busy_r;
    assign fsm_state      = state;

endmodule

// File: tb/tb_ffd_bank_write_ctrl.sv
// Bench for ffd_bank_write_ctrl: directed scenarios plus a random phase on an
// EN_CYCLES=1 instance checked every cycle against a transaction-level model,
// and a directed strobe-length check on an EN_CYCLES=3 instance.
module tb_ffd_bank_write_ctrl;
    import ffd_bank_write_ctrl_pkg::*;

    localparam int NREG   = 6;
    localparam int DATA_W = 3;
    localparam int ADDR_W = $clog2(NREG);
    localparam int E1     = 1;
    localparam int REC_W  = NREG + DATA_W + 5;
    localparam int OBS_W  = NREG + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ffd_bank_write_ctrl_if #(.NREG(NREG), .DATA_W(DATA_W)) bus1 ();
    ffd_bank_write_ctrl_if #(.NREG(NREG), .DATA_W(DATA_W)) bus3 ();
    state_t state1;
    state_t state3;

    ffd_bank_write_ctrl #(.NREG(NREG), .DATA_W(DATA_W), .EN_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .fsm_state(state1)
    );
    ffd_bank_write_ctrl #(.NREG(NREG), .DATA_W(DATA_W), .EN_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .fsm_state(state3)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each granted transaction is expanded into the cycle records the bank
    // should see: strobe cycles, acknowledge cycle, one idle cycle.
    logic [REC_W-1:0] exp_q[$];
    logic [OBS_W-1:0] obs_q[$];
    req_id_t          m_last  = REQ_B;
    logic [DATA_W-1:0] m_datos = '0;
    bit               mon_on  = 1'b0;
    int cnt_ack_a = 0, cnt_ack_b = 0, cnt_done = 0, cnt_err = 0, cnt_err_ackb = 0;

    function automatic logic [REC_W-1:0] rec(input logic [NREG-1:0] en, input logic [DATA_W-1:0] d,
                                             input logic aa, input logic ab, input logic cd,
                                             input logic er, input logic bz);
        return {en, d, aa, ab, cd, er, bz};
    endfunction

    function automatic logic [NREG-1:0] bit_of(input int i);
        return (i < NREG) ? (NREG'(1) << i) : '0;
    endfunction

    task automatic plan_write(input req_id_t who, input int addr, input logic [DATA_W-1:0] d);
        for (int c = 0; c < E1; c++) exp_q.push_back(rec(bit_of(addr), d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(rec('0, d, who == REQ_A, who == REQ_B, 1'b0, addr >= NREG, 1'b1));
        exp_q.push_back(rec('0, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_datos = d;
        m_last  = who;
    endtask

    task automatic plan_sweep();
        for (int i = 0; i < NREG; i++)
            for (int c = 0; c < E1; c++) exp_q.push_back(rec(bit_of(i), '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(rec('0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        exp_q.push_back(rec('0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        m_datos = '0;
    endtask

    task automatic decide();
        if (bus1.clr_req) plan_sweep();
        else if (bus1.req_a && bus1.req_b) begin
            if (m_last == REQ_B) plan_write(REQ_A, int'(bus1.addr_a), bus1.data_a);
            else                 plan_write(REQ_B, int'(bus1.addr_b), bus1.data_b);
        end
        else if (bus1.req_a) plan_write(REQ_A, int'(bus1.addr_a), bus1.data_a);
        else if (bus1.req_b) plan_write(REQ_B, int'(bus1.addr_b), bus1.data_b);
    endtask

    // Scoreboard: compare every cycle of dut1 on the falling edge.
    always @(negedge clk) begin : monitor
        logic [REC_W-1:0] want;
        logic [REC_W-1:0] got;
        if (mon_on) begin
            got = {bus1.enable_out, bus1.datos_out, bus1.ack_a, bus1.ack_b,
                   bus1.clr_done, bus1.err, bus1.busy};
            if (!reset) begin
                want = '0;
                exp_q.delete();
                m_last  = REQ_B;
                m_datos = '0;
            end else if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
            end else begin
                want = rec('0, m_datos, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            check("cycle", 32'(got), 32'(want));
            if (bus1.enable_out != '0) obs_q.push_back({bus1.enable_out, bus1.datos_out});
            if (reset) begin
                cnt_ack_a    += int'(bus1.ack_a);
                cnt_ack_b    += int'(bus1.ack_b);
                cnt_done     += int'(bus1.clr_done);
                cnt_err      += int'(bus1.err);
                cnt_err_ackb += int'(bus1.err && bus1.ack_b);
                if (exp_q.size() == 0) decide();
            end
        end
    end

    // ---------------- drivers ----------------
    bit rand_mode = 1'b0;

    task automatic new_a();
        bus1.req_a  = 1'b1;
        bus1.addr_a = ADDR_W'($urandom_range(0, 7));
        bus1.data_a = DATA_W'($urandom_range(0, 7));
    endtask

    task automatic new_b();
        bus1.req_b  = 1'b1;
        bus1.addr_b = ADDR_W'($urandom_range(0, 7));
        bus1.data_b = DATA_W'($urandom_range(0, 7));
    endtask

    // One clock cycle: observe acknowledges, then update request levels.
    task automatic step();
        logic sa, sb, sd;
        @(negedge clk);
        sa = bus1.ack_a;
        sb = bus1.ack_b;
        sd = bus1.clr_done;
        @(posedge clk);
        #1;
        if (sa) begin
            if (rand_mode && $urandom_range(0, 3) == 0) new_a();
            else bus1.req_a = 1'b0;
        end else if (rand_mode && !bus1.req_a && $urandom_range(0, 2) == 0) new_a();
        if (sb) begin
            if (rand_mode && $urandom_range(0, 3) == 0) new_b();
            else bus1.req_b = 1'b0;
        end else if (rand_mode && !bus1.req_b && $urandom_range(0, 2) == 0) new_b();
        if (sd) bus1.clr_req = 1'b0;
        else if (rand_mode && !bus1.clr_req && $urandom_range(0, 39) == 0) bus1.clr_req = 1'b1;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((bus1.req_a || bus1.req_b || bus1.clr_req || bus1.busy) && n < budget) begin
            step();
            n++;
        end
        check({tag, "_finished"}, 32'(n < budget), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.clr_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_a(input int addr, input int d);
        bus1.req_a = 1'b1; bus1.addr_a = ADDR_W'(addr); bus1.data_a = DATA_W'(d);
    endtask

    task automatic set_b(input int addr, input int d);
        bus1.req_b = 1'b1; bus1.addr_b = ADDR_W'(addr); bus1.data_b = DATA_W'(d);
    endtask

    task automatic check_obs(input string tag, input int idx, input int en, input int d);
        logic [31:0] got;
        logic [OBS_W-1:0] want;
        want = {NREG'(en), DATA_W'(d)};
        got  = (idx < obs_q.size()) ? 32'(obs_q[idx]) : 32'hdead;
        check(tag, got, 32'(want));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int a0, d0, n;
        logic [6:0] s3;
        logic [6:0] e3;

        bus1.req_a = 0; bus1.addr_a = '0; bus1.data_a = '0;
        bus1.req_b = 0; bus1.addr_b = '0; bus1.data_b = '0; bus1.clr_req = 0;
        bus3.req_a = 0; bus3.addr_a = '0; bus3.data_a = '0;
        bus3.req_b = 0; bus3.addr_b = '0; bus3.data_b = '0; bus3.clr_req = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_enable", 32'(bus1.enable_out), 32'd0);
        check("rst_datos",  32'(bus1.datos_out), 32'd0);
        check("rst_flags",  32'({bus1.ack_a, bus1.ack_b, bus1.clr_done, bus1.err, bus1.busy}), 32'd0);
        check("rst_state",  32'(state1), 32'(IDLE));
        check("rst_state3", 32'(state3), 32'(IDLE));
        check("rst_enable3", 32'(bus3.enable_out), 32'd0);

        // Single write from reset.
        mon_on = 1'b1;
        set_a(2, 5);
        @(posedge clk);
        #1;
        reset = 1'b1;
        obs_q.delete();
        a0 = cnt_ack_a;
        run_until_idle("single", 20);
        check("single_count", 32'(obs_q.size()), 32'd1);
        check_obs("single_write", 0, 6'b000100, 3'b101);
        check("single_ack", 32'(cnt_ack_a - a0), 32'd1);
        check("single_busy", 32'(bus1.busy), 32'd0);

        // Contested pair after reset: A first, then B.
        pulse_reset();
        obs_q.delete();
        set_a(1, 3); set_b(4, 6);
        run_until_idle("pair1", 30);
        check_obs("pair1_first", 0, 6'b000010, 3'b011);
        check_obs("pair1_second", 1, 6'b010000, 3'b110);

        // A alone, then another contested pair: B now wins.
        obs_q.delete();
        set_a(0, 1);
        run_until_idle("solo_a", 20);
        set_a(1, 3); set_b(4, 6);
        run_until_idle("pair2", 30);
        check_obs("solo_a_write", 0, 6'b000001, 3'b001);
        check_obs("pair2_first", 1, 6'b010000, 3'b110);
        check_obs("pair2_second", 2, 6'b000010, 3'b011);

        // Clear-all outranks a pending A write.
        obs_q.delete();
        d0 = cnt_done;
        bus1.clr_req = 1'b1;
        set_a(5, 7);
        run_until_idle("sweep", 40);
        check("sweep_count", 32'(obs_q.size()), 32'd7);
        for (int i = 0; i < NREG; i++) check_obs("sweep_step", i, 1 << i, 0);
        check_obs("sweep_then_a", 6, 6'b100000, 3'b111);
        check("sweep_done", 32'(cnt_done - d0), 32'd1);

        // Out-of-range address: no strobe, err together with ack_b.
        obs_q.delete();
        a0 = cnt_err_ackb;
        d0 = cnt_err;
        set_b(7, 2);
        run_until_idle("bad_addr", 20);
        check("bad_addr_strobes", 32'(obs_q.size()), 32'd0);
        check("bad_addr_err_ack", 32'(cnt_err_ackb - a0), 32'd1);
        check("bad_addr_err", 32'(cnt_err - d0), 32'd1);

        // Reset in the middle of a sweep at index 3.
        d0 = cnt_done;
        bus1.clr_req = 1'b1;
        n = 0;
        while (bus1.enable_out != 6'b001000 && n < 20) begin
            step();
            n++;
        end
        check("abort_reach", 32'(bus1.enable_out), 32'(6'b001000));
        reset = 1'b0;
        #1;
        check("abort_enable", 32'(bus1.enable_out), 32'd0);
        check("abort_busy", 32'(bus1.busy), 32'd0);
        bus1.clr_req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("abort_state", 32'(state1), 32'(IDLE));
        check("abort_no_done", 32'(cnt_done - d0), 32'd0);
        obs_q.delete();
        bus1.clr_req = 1'b1;
        run_until_idle("resweep", 40);
        check("resweep_count", 32'(obs_q.size()), 32'd6);
        check_obs("resweep_first", 0, 6'b000001, 3'b000);

        // EN_CYCLES=3 instance: strobe held three cycles, ack in the fourth.
        bus3.req_a = 1'b1; bus3.addr_a = ADDR_W'(2); bus3.data_a = DATA_W'(5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            s3 = {bus3.enable_out, bus3.ack_a};
            e3 = (k >= 1 && k <= 3) ? {6'b000100, 1'b0} : (k == 4) ? {6'b000000, 1'b1} : 7'd0;
            check($sformatf("en3_cycle%0d", k), 32'(s3), 32'(e3));
            if (k >= 1 && k <= 4) check($sformatf("en3_datos%0d", k), 32'(bus3.datos_out), 32'd5);
            if (k == 4) bus3.req_a = 1'b0;
            if (k == 5) check("en3_busy_after", 32'(bus3.busy), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random traffic on the EN_CYCLES=1 instance.
        rand_mode = 1'b1;
        repeat (2000) step();
        rand_mode = 1'b0;
        run_until_idle("random_drain", 100);
        repeat (3) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
